ad_frame_pack: RTL
==================

# ad_frame_pack

Downstream stage of the signal-select block: it takes the registered monopulse channels (AD_he sum, AD_fw azimuth difference, AD_fy elevation difference) and, on every PRI rising edge, captures a programmable range window of samples. Each window becomes one framed packet: a header word followed by sample words. Packets are buffered and streamed out over a valid/ready interface to the SRIO packetiser. Whole frames are admitted or dropped atomically, so the downstream side never sees a partial packet.

## Interface
Parameters:
- FIFO_AW, 11, FIFO address width (depth 2048 words of 66 bits: data[63:0], sop, eop)
- MAX_LEN, 1024, maximum samples per window (win_len clamp value)

Ports:
- clk_100M  in  1  system clock; one clock domain only
- rst_n  in  1  reset, asynchronous, active-low
- AD_he  in  16  sum channel, two's complement, synchronous to clk_100M
- AD_fw  in  16  azimuth difference channel
- AD_fy  in  16  elevation difference channel
- PRI  in  1  pulse repetition strobe, synchronous to clk_100M, level (≥1 cycle high)
- pri_code  in  16  PRI code, latched into the header
- wave_code  in  8  waveform code, latched into the header
- win_start  in  16  delay in cycles from the PRI edge to the first sample
- win_len  in  11  samples per window; 0 = no frame; values >MAX_LEN are clamped to MAX_LEN
- out_data  out  64  packet word
- out_valid  out  1  out_data valid
- out_sop  out  1  header word marker
- out_eop  out  1  last sample word marker
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- frame_cnt  out  16  count of admitted frames; wraps 0xFFFF→0
- drop_cnt  out  16  count of frames dropped for lack of space; saturates at 0xFFFF
- pri_overrun  out  1  sticky flag; set when a PRI edge arrives while not IDLE; cleared only by reset

## Operation
- Edge detect: pri_d is the registered PRI. An edge is PRI && !pri_d.
- State machine IDLE → DELAY → CAPTURE → IDLE.
- IDLE, on an edge:
  - Latch win_start, the clamped win_len (len_q), pri_code and wave_code.
  - If len_q == 0, stay in IDLE; no write, no counter change.
  - Else if FIFO free space < len_q+1, drop the frame: drop_cnt++, stay in IDLE.
  - Else push the header on the next cycle: {8'hA5, wave_code, pri_code, frame_cnt, 16'h0000} with sop=1, eop=0. The header carries frame_cnt's value before the increment; frame_cnt increments in the same cycle.
  - Enter DELAY with dcnt = win_start.
- DELAY: decrement dcnt each cycle. When dcnt == 0, enter CAPTURE. win_start == 0 enters CAPTURE on the cycle after the edge cycle.
- CAPTURE: push one word per cycle, {AD_fy, AD_fw, AD_he, idx[15:0]}, with idx running 0..len_q-1. eop=1 on idx == len_q-1. Return to IDLE after the last word.
- Edges seen in DELAY or CAPTURE are ignored and set pri_overrun. An edge in the same cycle the FSM returns to IDLE is also ignored.
- The admission check is what guarantees no partial frames, so the FIFO never overflows. Writing while full is a design error; an assertion must catch it.
- Output side uses first-word-fall-through registering. out_data/out_sop/out_eop hold stable while out_valid && !out_ready. The FIFO reads and writes simultaneously when needed; the free-space count uses the pre-update occupancy (conservative).
- Reset, including mid-frame: FIFO is emptied and the FSM returns to IDLE. Any partial frame is discarded.

## Timing
- Reset values: out_data=0, out_valid=0, out_sop=0, out_eop=0, frame_cnt=0, drop_cnt=0, pri_overrun=0. FSM = IDLE, FIFO empty, pri_d=0.
- Edge cycle T is the first cycle with PRI=1 sampled after pri_d=0.
- Header is written at T+1. First sample captures the AD_* inputs present at cycle T+1+win_start. Sample k captures inputs at T+1+win_start+k.
- Write-to-out_valid latency is 2 cycles with an empty FIFO: header visible at T+3.
- With out_ready held high: one word per cycle, and a full frame of len_q+1 words is contiguous.
- Minimum PRI period for no overrun is win_start + len_q + 2 cycles.

## Test plan
- Basic frame: win_start=10, win_len=4, AD_he = ramp, out_ready=1, PRI edge at T. Required: header at T+3 with sop=1 and the frame_cnt field = 0; then 4 words with idx 0..3, samples taken at T+11..T+14; eop on idx 3; frame_cnt becomes 1.
- Backpressure: out_ready toggled 1010..., win_len=8. Required: all 9 words delivered in order, none duplicated or lost, and data stable whenever ready=0.
- Drop: out_ready=0, win_len=1024 at each PRI. Required: frame 1 admitted (1025 words); frame 2 dropped because free space 1023 < 1025; drop_cnt=1; frame_cnt=1; no partial packet ever appears.
- Overrun: PRI edge 5 cycles after the first edge with win_start=20. Required: pri_overrun=1; only one frame produced.
- Boundaries: win_len=0 produces no output and no counter change. win_len=2047 is clamped: 1024 samples, eop at idx 1023. win_start=0 takes its first sample at T+1.
- Mid-frame reset: assert rst_n=0 during CAPTURE. Required: all outputs go to reset values immediately; after release, the next PRI produces a clean frame with header frame_cnt field = 0.

Source files
------------

// File: rtl/ad_frame_pack.sv
// ad_frame_pack: captures a PRI-triggered range window of AD_he/AD_fw/AD_fy
// into header+sample packets and streams them out through a buffering FIFO.
// Ports: clk_100M, rst_n (async, active-low); AD_he/AD_fw/AD_fy sample
// inputs; PRI strobe; pri_code/wave_code header fields; win_start/win_len
// window control; out_data/out_valid/out_sop/out_eop with out_ready
// handshake; frame_cnt, drop_cnt and sticky pri_overrun status.
module ad_frame_pack #(
    parameter int FIFO_AW = 11,
    parameter int MAX_LEN = 1024
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic [15:0] AD_he,
    input  logic [15:0] AD_fw,
    input  logic [15:0] AD_fy,
    input  logic        PRI,
    input  logic [15:0] pri_code,
    input  logic [7:0]  wave_code,
    input  logic [15:0] win_start,
    input  logic [10:0] win_len,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    input  logic        out_ready,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic        pri_overrun
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CAPTURE
    } state_t;

    state_t             state;
    logic               pri_d;
    logic               edge_det;
    logic               just_done;
    logic [15:0]        dcnt;
    logic [10:0]        len_q;
    logic [10:0]        len_clamp;
    logic [10:0]        idx;
    logic [16:0]        room;
    logic [16:0]        need;

    // FIFO word layout: {sop, eop, data[63:0]}
    logic               wr_q;
    logic [65:0]        wr_word;
    logic [65:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wp;
    logic [FIFO_AW-1:0] rp;
    logic [FIFO_AW:0]   count;
    logic               rd_en;

    assign edge_det  = PRI && !pri_d;
    assign len_clamp = (win_len > 11'(MAX_LEN)) ? 11'(MAX_LEN) : win_len;

    // Staged word not yet counted in occupancy is reserved as well.
    assign room = 17'(DEPTH) - 17'(count) - 17'(wr_q);
    assign need = 17'(len_clamp) + 17'd1;

    assign rd_en = (count != '0) && (!out_valid || out_ready);

    // Capture FSM. Every FIFO write goes through the wr_q/wr_word stage,
    // so the header (staged at T+1) and a win_start=0 first sample
    // (captured at T+1, staged at T+2) never collide.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pri_d       <= 1'b0;
            just_done   <= 1'b0;
            dcnt        <= '0;
            len_q       <= '0;
            idx         <= '0;
            wr_q        <= 1'b0;
            wr_word     <= '0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            pri_overrun <= 1'b0;
        end else begin
            pri_d     <= PRI;
            wr_q      <= 1'b0;
            just_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The first IDLE cycle after a frame still rejects edges.
                    if (edge_det && just_done) begin
                        pri_overrun <= 1'b1;
                    end else if (edge_det) begin
                        len_q <= len_clamp;
                        idx   <= '0;
                        if (len_clamp == '0) begin
                            state <= IDLE;
                        end else if (room < need) begin
                            if (drop_cnt != 16'hFFFF)
                                drop_cnt <= drop_cnt + 16'd1;
                        end else begin
                            wr_q      <= 1'b1;
                            wr_word   <= {2'b10, 8'hA5, wave_code,
                                          pri_code, frame_cnt, 16'h0000};
                            frame_cnt <= frame_cnt + 16'd1;
                            if (win_start == '0) begin
                                state <= CAPTURE;
                            end else begin
                                dcnt  <= win_start - 16'd1;
                                state <= DELAY;
                            end
                        end
                    end
                end
                DELAY: begin
                    if (edge_det)
                        pri_overrun <= 1'b1;
                    if (dcnt == '0)
                        state <= CAPTURE;
                    else
                        dcnt <= dcnt - 16'd1;
                end
                CAPTURE: begin
                    if (edge_det)
                        pri_overrun <= 1'b1;
                    wr_q    <= 1'b1;
                    wr_word <= {1'b0, (idx == len_q - 11'd1),
                                AD_fy, AD_fw, AD_he, 5'd0, idx};
                    idx     <= idx + 11'd1;
                    if (idx == len_q - 11'd1) begin
                        state     <= IDLE;
                        just_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100M) begin
        if (wr_q)
            mem[wp] <= wr_word;
    end

    // Pointers, occupancy and the first-word-fall-through output register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            if (wr_q)
                wp <= wp + 1'b1;
            if (rd_en)
                rp <= rp + 1'b1;
            unique case ({wr_q, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rd_en) begin
                {out_sop, out_eop, out_data} <= mem[rp];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Admission control must make a write into a full FIFO impossible.
    a_no_overflow: assert property (
        @(posedge clk_100M) disable iff (!rst_n)
        !(wr_q && count[FIFO_AW])
    );

endmodule
